rvfi_cover_counters: RTL and testbench

RVFI_COVER_COUNTERS -- requirements
Module: rvfi_cover_counters

---
 rtl/rvfi_cover_counters.sv | 158 +++++++++++++++
 tb/tb_rvfi_cover_counters.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_cover_counters.sv
// RVFI retirement coverage counters.
// Counts retirements per channel and per class (trap / interrupt / normal),
// counts rollback events, tracks the pre/post-rollback phase and counts
// retirements after the first rollback. All counters saturate at all-ones.
module rvfi_cover_counters #(
    parameter int NRET   = 1,
    parameter int CNT_W  = 16,
    parameter int TARGET = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic [NRET-1:0]       rvfi_valid,
    input  logic [NRET-1:0]       rvfi_trap,
    input  logic [NRET-1:0]       rvfi_intr,
    input  logic                  rvfi_rollback_valid,
    output logic [NRET*CNT_W-1:0] cnt_insns,
    output logic [NRET*CNT_W-1:0] cnt_trap,
    output logic [NRET*CNT_W-1:0] cnt_intr,
    output logic [NRET*CNT_W-1:0] cnt_norm,
    output logic [NRET*CNT_W-1:0] arb_cnt_insns,
    output logic [CNT_W-1:0]      total_insns,
    output logic [CNT_W-1:0]      cnt_rollback,
    output logic                  sat,
    output logic                  reached,
    output logic                  state
);

    typedef enum logic {PRE_RB = 1'b0, POST_RB = 1'b1} phase_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               NOVF    = 5 * NRET + 2;

    phase_t                  state_q;
    phase_t                  state_d;
    logic                    arb_en;
    logic [3:0]              pop;
    logic [NOVF-1:0]         ovf;
    logic [NRET*CNT_W-1:0]   insns_d;
    logic [NRET*CNT_W-1:0]   trap_d;
    logic [NRET*CNT_W-1:0]   intr_d;
    logic [NRET*CNT_W-1:0]   norm_d;
    logic [NRET*CNT_W-1:0]   arb_d;
    logic [CNT_W-1:0]        total_d;
    logic [CNT_W-1:0]        rollback_d;
    logic                    sat_d;
    logic                    reached_d;

    // Saturating increment; MSB of the result flags an attempted overflow.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (!en)
            return {1'b0, v};
        if (v == CNT_MAX)
            return {1'b1, CNT_MAX};
        return {1'b0, v + 1'b1};
    endfunction

    // Saturating add of a small popcount; MSB flags that the sum was clamped.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] v, input logic [3:0] n);
        logic [CNT_W:0] sum;
        sum = {1'b0, v} + (CNT_W + 1)'(n);
        if (sum > {1'b0, CNT_MAX})
            return {1'b1, CNT_MAX};
        return sum;
    endfunction

    // Phase register: PRE_RB until the first rollback.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state_q <= PRE_RB;
        else
            state_q <= state_d;
    end

    // Next phase: rollback moves to POST_RB, only clear returns to PRE_RB.
    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = PRE_RB;
        else if (rvfi_rollback_valid)
            state_d = POST_RB;
    end

    // Phase outputs: a retirement coincident with the rollback already counts as post-rollback.
    always_comb begin
        state  = state_q;
        arb_en = (state_q == POST_RB) || rvfi_rollback_valid;
    end

    // Number of channels retiring this cycle.
    always_comb begin
        pop = '0;
        for (int k = 0; k < NRET; k++)
            pop = pop + 4'(rvfi_valid[k]);
    end

    // Next counter values; trap takes precedence over interrupt in classification.
    always_comb begin
        ovf     = '0;
        insns_d = cnt_insns;
        trap_d  = cnt_trap;
        intr_d  = cnt_intr;
        norm_d  = cnt_norm;
        arb_d   = arb_cnt_insns;
        for (int k = 0; k < NRET; k++) begin
            {ovf[5*k+0], insns_d[k*CNT_W +: CNT_W]} =
                sat_inc(cnt_insns[k*CNT_W +: CNT_W], rvfi_valid[k]);
            {ovf[5*k+1], trap_d[k*CNT_W +: CNT_W]} =
                sat_inc(cnt_trap[k*CNT_W +: CNT_W], rvfi_valid[k] & rvfi_trap[k]);
            {ovf[5*k+2], intr_d[k*CNT_W +: CNT_W]} =
                sat_inc(cnt_intr[k*CNT_W +: CNT_W], rvfi_valid[k] & ~rvfi_trap[k] & rvfi_intr[k]);
            {ovf[5*k+3], norm_d[k*CNT_W +: CNT_W]} =
                sat_inc(cnt_norm[k*CNT_W +: CNT_W], rvfi_valid[k] & ~rvfi_trap[k] & ~rvfi_intr[k]);
            {ovf[5*k+4], arb_d[k*CNT_W +: CNT_W]} =
                sat_inc(arb_cnt_insns[k*CNT_W +: CNT_W], rvfi_valid[k] & arb_en);
        end
        {ovf[5*NRET], total_d}      = sat_add(total_insns, pop);
        {ovf[5*NRET+1], rollback_d} = sat_inc(cnt_rollback, rvfi_rollback_valid);
        sat_d     = sat | (|ovf);
        reached_d = reached | (32'(total_d) >= 32'(TARGET));
    end

    // Counter and sticky-flag registers; clear discards any event of the same cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_insns     <= '0;
            cnt_trap      <= '0;
            cnt_intr      <= '0;
            cnt_norm      <= '0;
            arb_cnt_insns <= '0;
            total_insns   <= '0;
            cnt_rollback  <= '0;
            sat           <= 1'b0;
            reached       <= 1'b0;
        end else if (clear) begin
            cnt_insns     <= '0;
            cnt_trap      <= '0;
            cnt_intr      <= '0;
            cnt_norm      <= '0;
            arb_cnt_insns <= '0;
            total_insns   <= '0;
            cnt_rollback  <= '0;
            sat           <= 1'b0;
            reached       <= 1'b0;
        end else begin
            cnt_insns     <= insns_d;
            cnt_trap      <= trap_d;
            cnt_intr      <= intr_d;
            cnt_norm      <= norm_d;
            arb_cnt_insns <= arb_d;
            total_insns   <= total_d;
            cnt_rollback  <= rollback_d;
            sat           <= sat_d;
            reached       <= reached_d;
        end
    end

endmodule

// File: tb/tb_rvfi_cover_counters.sv
// Directed bench for rvfi_cover_counters: an 8-bit instance (a_*) and a
// 4-bit instance (b_*) share the same stimulus.
module tb_rvfi_cover_counters;

    logic       clk;
    logic       resetn;
    logic       clear;
    logic [1:0] valid;
    logic [1:0] trap;
    logic [1:0] intr;
    logic       rb;

    logic [15:0] a_insns, a_trap, a_intr, a_norm, a_arb;
    logic [7:0]  a_total, a_rb;
    logic        a_sat, a_reached, a_state;

    logic [7:0]  b_insns, b_trap, b_intr, b_norm, b_arb;
    logic [3:0]  b_total, b_rb;
    logic        b_sat, b_reached, b_state;

    int vectors;
    int miscompares;

    rvfi_cover_counters #(.NRET(2), .CNT_W(8), .TARGET(8)) u_a (
        .clock(clk), .resetn(resetn), .clear(clear),
        .rvfi_valid(valid), .rvfi_trap(trap), .rvfi_intr(intr),
        .rvfi_rollback_valid(rb),
        .cnt_insns(a_insns), .cnt_trap(a_trap), .cnt_intr(a_intr), .cnt_norm(a_norm),
        .arb_cnt_insns(a_arb), .total_insns(a_total), .cnt_rollback(a_rb),
        .sat(a_sat), .reached(a_reached), .state(a_state)
    );

    rvfi_cover_counters #(.NRET(2), .CNT_W(4), .TARGET(8)) u_b (
        .clock(clk), .resetn(resetn), .clear(clear),
        .rvfi_valid(valid), .rvfi_trap(trap), .rvfi_intr(intr),
        .rvfi_rollback_valid(rb),
        .cnt_insns(b_insns), .cnt_trap(b_trap), .cnt_intr(b_intr), .cnt_norm(b_norm),
        .arb_cnt_insns(b_arb), .total_insns(b_total), .cnt_rollback(b_rb),
        .sat(b_sat), .reached(b_reached), .state(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the currently driven inputs, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; valid = 2'b00; trap = 2'b00; intr = 2'b00; rb = 1'b0;
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        resetn = 1'b0;
        idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_total", a_total, 0);
        chk("reset_insns", a_insns, 0);
        chk("reset_state", a_state, 0);
        chk("reset_sat_reached", {a_sat, a_reached, b_sat, b_reached}, 0);
        resetn = 1'b1;
        tick();

        // Two channels, trap on ch0, normal on ch1
        valid = 2'b11; trap = 2'b01;
        tick();
        idle();
        chk("cls_trap0", a_trap, 16'h0001);
        chk("cls_norm1", a_norm, 16'h0100);
        chk("cls_total", a_total, 2);
        chk("cls_insns", a_insns, 16'h0101);
        chk("cls_intr", a_intr, 0);

        clear = 1'b1;
        tick();
        idle();
        chk("clear_total", a_total, 0);

        // Trap and interrupt together count as trap only
        valid = 2'b01; trap = 2'b01; intr = 2'b01;
        tick();
        idle();
        chk("both_trap", a_trap, 16'h0001);
        chk("both_intr", a_intr, 0);
        chk("both_insns", a_insns, 16'h0001);

        // Interrupt-only on ch1
        valid = 2'b10; intr = 2'b10;
        tick();
        idle();
        chk("intr1", a_intr, 16'h0100);
        chk("intr1_norm", a_norm, 0);

        // Flags without valid are ignored
        trap = 2'b11; intr = 2'b11;
        tick();
        idle();
        chk("novalid_total", a_total, 2);
        chk("novalid_trap", a_trap, 16'h0001);

        clear = 1'b1;
        tick();
        idle();

        // Saturation on the 4-bit instance, reached on the 8-bit one
        for (int i = 1; i <= 20; i++) begin
            valid = 2'b01;
            tick();
            chk("sat_b_insns0", b_insns[3:0], (i > 15) ? 15 : i);
            chk("sat_b_total", b_total, (i > 15) ? 15 : i);
            chk("sat_b_flag", b_sat, (i > 15) ? 1 : 0);
            chk("sat_a_total", a_total, i);
            chk("sat_a_reached", a_reached, (i >= 8) ? 1 : 0);
        end
        idle();
        chk("sat_a_flag", a_sat, 0);

        // Two channels at once on an already clamped total
        valid = 2'b11;
        tick();
        idle();
        chk("clamp_b_total", b_total, 15);
        chk("clamp_b_insns1", b_insns[7:4], 1);

        clear = 1'b1;
        tick();
        idle();
        chk("clear_b_sat", b_sat, 0);
        chk("clear_b_total", b_total, 0);
        chk("clear_a_reached", a_reached, 0);

        // Pre-rollback retirements do not count toward arb counters
        valid = 2'b11;
        tick();
        idle();
        chk("pre_rb_arb", a_arb, 0);
        chk("pre_rb_state", a_state, 0);

        // Rollback with coincident retirement, then three more
        valid = 2'b01; rb = 1'b1;
        tick();
        idle();
        chk("rb_state", a_state, 1);
        chk("rb_count", a_rb, 1);
        chk("rb_arb_first", a_arb, 16'h0001);
        valid = 2'b01;
        repeat (3) tick();
        idle();
        chk("rb_arb", a_arb, 16'h0004);
        chk("rb_insns", a_insns, 16'h0105);
        chk("rb_state_hold", a_state, 1);

        // Second rollback strobe in POST_RB
        rb = 1'b1;
        tick();
        idle();
        chk("rb_count2", a_rb, 2);
        chk("rb_state2", a_state, 1);

        clear = 1'b1;
        tick();
        idle();

        // Reached after four dual retirements
        valid = 2'b11;
        repeat (3) tick();
        chk("reach_before", a_reached, 0);
        tick();
        chk("reach_after", a_reached, 1);
        chk("reach_total", a_total, 8);

        // Clear wins over coincident events
        clear = 1'b1; valid = 2'b11; rb = 1'b1;
        tick();
        idle();
        chk("clrwin_total", a_total, 0);
        chk("clrwin_flags", {a_reached, a_state, a_sat}, 0);
        chk("clrwin_insns", a_insns, 0);
        chk("clrwin_rb", a_rb, 0);
        tick();
        chk("clrwin_hold", a_reached, 0);

        // Asynchronous reset between edges
        valid = 2'b11; rb = 1'b1;
        tick();
        rb = 1'b0;
        tick();
        idle();
        chk("prereset_total", a_total, 4);
        chk("prereset_state", a_state, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_total", a_total, 0);
        chk("async_state", a_state, 0);
        chk("async_insns", a_insns, 0);
        chk("async_b_total", b_total, 0);
        #1;
        resetn = 1'b1;
        valid = 2'b01;
        tick();
        idle();
        chk("restart_total", a_total, 1);
        chk("restart_insns", a_insns, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
